// File: rtl/op_logic_pipe.sv
// Two-stage logical-operation pipeline. Stage 1 captures the shifted operand 2 and
// shifter carry; stage 2 captures the logic result and the updated flags.
module op_logic_pipe #(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic             IMM,
  input  logic             S,
  input  logic [WIDTH-1:0] Rn,
  input  logic [WIDTH-1:0] Rm,
  input  logic [11:0]      imm_operand,
  input  logic [1:0]       stype,
  input  logic [SHW-1:0]   imm_shift,
  input  logic             carry_in,
  input  logic             zero_in,
  input  logic             neg_in,
  input  logic             ovf_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Rd,
  output logic             carry_out,
  output logic             zero_out,
  output logic             neg_out,
  output logic             ovf_out
);

  typedef enum logic [1:0] {
    SH_LSL = 2'b00,
    SH_LSR = 2'b01,
    SH_ASR = 2'b10,
    SH_ROR = 2'b11
  } shift_e;

  typedef enum logic [2:0] {
    OP_AND = 3'b000,
    OP_ORR = 3'b001,
    OP_EOR = 3'b010,
    OP_BIC = 3'b011,
    OP_MOV = 3'b100,
    OP_MVN = 3'b101
  } op_e;

  // ---------------------------------------------------------------------------
  // Handshake
  // ---------------------------------------------------------------------------
  logic s1_valid;
  logic s2_valid;
  logic s2_ready;

  assign s2_ready = !s2_valid || out_ready;
  assign in_ready = !s1_valid || s2_ready;

  // ---------------------------------------------------------------------------
  // Barrel shifter (operand 2)
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0]        imm_ext;
  logic                    imm_unused;
  logic [WIDTH:0]          lsl_w;
  logic [WIDTH:0]          lsr_w;
  logic signed [WIDTH:0]   asr_w;
  logic [SHW:0]            ror_back;
  logic [WIDTH-1:0]        ror_v;
  logic [WIDTH-1:0]        sh_op2;
  logic                    sh_c;

  // Narrow datapaths drop the upper immediate bits.
  assign imm_ext    = WIDTH'(imm_operand);
  assign imm_unused = ^imm_operand;

  // The extra guard bit in each wide shift lands exactly on the shifter carry.
  always_comb begin
    // NOTE: every variable written here gets a default first so no latch is inferred.
    lsl_w    = {1'b0, Rm} << imm_shift;
    lsr_w    = {Rm, 1'b0} >> imm_shift;
    asr_w    = $signed({Rm, 1'b0}) >>> imm_shift;
    ror_back = (SHW+1)'(WIDTH) - (SHW+1)'(imm_shift);
    ror_v    = (Rm >> imm_shift) | (Rm << ror_back);
    sh_op2   = Rm;
    sh_c     = carry_in;

    if (IMM) begin
      sh_op2 = imm_ext;
      sh_c   = carry_in;
    end else if (imm_shift == '0) begin
      // Zero shift amounts encode the special forms (LSR/ASR by WIDTH, RRX).
      case (shift_e'(stype))
        SH_LSL: begin
          sh_op2 = Rm;
          sh_c   = carry_in;
        end
        SH_LSR: begin
          sh_op2 = '0;
          sh_c   = Rm[WIDTH-1];
        end
        SH_ASR: begin
          sh_op2 = {WIDTH{Rm[WIDTH-1]}};
          sh_c   = Rm[WIDTH-1];
        end
        default: begin
          sh_op2 = {carry_in, Rm[WIDTH-1:1]};
          sh_c   = Rm[0];
        end
      endcase
    end else begin
      case (shift_e'(stype))
        SH_LSL: begin
          sh_op2 = lsl_w[WIDTH-1:0];
          sh_c   = lsl_w[WIDTH];
        end
        SH_LSR: begin
          sh_op2 = lsr_w[WIDTH:1];
          sh_c   = lsr_w[0];
        end
        SH_ASR: begin
          sh_op2 = asr_w[WIDTH:1];
          sh_c   = asr_w[0];
        end
        default: begin
          sh_op2 = ror_v;
          sh_c   = lsr_w[0];
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 1 registers
  // ---------------------------------------------------------------------------
  op_e              s1_op;
  logic             s1_s;
  logic [WIDTH-1:0] s1_rn;
  logic [WIDTH-1:0] s1_op2;
  logic             s1_shc;
  logic             s1_c;
  logic             s1_z;
  logic             s1_n;
  logic             s1_v;

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments keep every register reading pre-edge values.
    if (rst) begin
      s1_valid <= 1'b0;
    end else if (in_ready) begin
      s1_valid <= in_valid;
    end
  end

  // NOTE: payload registers carry no reset; the valid bits alone qualify them.
  always_ff @(posedge clk) begin
    if (in_valid && in_ready) begin
      s1_op  <= op_e'(op);
      s1_s   <= S;
      s1_rn  <= Rn;
      s1_op2 <= sh_op2;
      s1_shc <= sh_c;
      s1_c   <= carry_in;
      s1_z   <= zero_in;
      s1_n   <= neg_in;
      s1_v   <= ovf_in;
    end
  end

  // ---------------------------------------------------------------------------
  // Logic unit and flag update
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0] res;
  logic             c_next;
  logic             z_next;
  logic             n_next;
  logic             v_next;

  always_comb begin
    case (s1_op)
      OP_AND:  res = s1_rn & s1_op2;
      OP_ORR:  res = s1_rn | s1_op2;
      OP_EOR:  res = s1_rn ^ s1_op2;
      OP_BIC:  res = s1_rn & ~s1_op2;
      OP_MVN:  res = ~s1_op2;
      default: res = s1_op2;
    endcase

    if (s1_s) begin
      c_next = s1_shc;
      z_next = (res == '0);
      n_next = res[WIDTH-1];
      v_next = s1_v;
    end else begin
      c_next = s1_c;
      z_next = s1_z;
      n_next = s1_n;
      v_next = s1_v;
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 2 registers (drive the outputs directly)
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0] s2_rd;
  logic             s2_c;
  logic             s2_z;
  logic             s2_n;
  logic             s2_v;

  always_ff @(posedge clk) begin
    if (rst) begin
      s2_valid <= 1'b0;
      s2_rd    <= '0;
      s2_c     <= 1'b0;
      s2_z     <= 1'b0;
      s2_n     <= 1'b0;
      s2_v     <= 1'b0;
    end else begin
      if (s2_ready) begin
        s2_valid <= s1_valid;
      end
      if (s1_valid && s2_ready) begin
        s2_rd <= res;
        s2_c  <= c_next;
        s2_z  <= z_next;
        s2_n  <= n_next;
        s2_v  <= v_next;
      end
    end
  end

  assign out_valid = s2_valid;
  assign Rd        = s2_rd;
  assign carry_out = s2_c;
  assign zero_out  = s2_z;
  assign neg_out   = s2_n;
  assign ovf_out   = s2_v;

endmodule

// File: tb/tb_op_logic_pipe.sv
// Directed self-checking bench for op_logic_pipe: 32-bit instance for the datapath
// and handshake, 8-bit instance for immediate truncation and mid-flight reset.
module tb_op_logic_pipe;

  localparam logic [2:0] AND_OP = 3'b000;
  localparam logic [2:0] ORR_OP = 3'b001;
  localparam logic [2:0] EOR_OP = 3'b010;
  localparam logic [2:0] BIC_OP = 3'b011;
  localparam logic [2:0] MOV_OP = 3'b100;
  localparam logic [2:0] MVN_OP = 3'b101;
  localparam logic [1:0] LSL = 2'b00;
  localparam logic [1:0] LSR = 2'b01;
  localparam logic [1:0] ASR = 2'b10;
  localparam logic [1:0] ROR = 2'b11;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // 32-bit instance
  logic        rst, in_valid, in_ready, imm, s, out_valid, out_ready;
  logic [2:0]  op;
  logic [31:0] rn, rm, rd;
  logic [11:0] imm_operand;
  logic [1:0]  stype;
  logic [4:0]  imm_shift;
  logic        cin, zin, nin, vin, cout, zout, nout, vout;

  // 8-bit instance
  logic        rst8, in_valid8, in_ready8, imm8, s8, out_valid8, out_ready8;
  logic [2:0]  op8;
  logic [7:0]  rn8, rm8, rd8;
  logic [11:0] imm_op8;
  logic [1:0]  stype8;
  logic [2:0]  sh8;
  logic        cin8, zin8, nin8, vin8, cout8, zout8, nout8, vout8;

  op_logic_pipe #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .op(op),
    .IMM(imm), .S(s), .Rn(rn), .Rm(rm), .imm_operand(imm_operand), .stype(stype),
    .imm_shift(imm_shift), .carry_in(cin), .zero_in(zin), .neg_in(nin), .ovf_in(vin),
    .out_valid(out_valid), .out_ready(out_ready), .Rd(rd), .carry_out(cout),
    .zero_out(zout), .neg_out(nout), .ovf_out(vout)
  );

  op_logic_pipe #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst8), .in_valid(in_valid8), .in_ready(in_ready8), .op(op8),
    .IMM(imm8), .S(s8), .Rn(rn8), .Rm(rm8), .imm_operand(imm_op8), .stype(stype8),
    .imm_shift(sh8), .carry_in(cin8), .zero_in(zin8), .neg_in(nin8), .ovf_in(vin8),
    .out_valid(out_valid8), .out_ready(out_ready8), .Rd(rd8), .carry_out(cout8),
    .zero_out(zout8), .neg_out(nout8), .ovf_out(vout8)
  );

  // Presents one request with out_ready high and returns the result, its flags
  // {C,Z,N,V} and the number of clock edges from acceptance edge to out_valid.
  task automatic drive_one(input logic [2:0] o, input logic i_b, input logic s_b,
                           input logic [31:0] rn_v, input logic [31:0] rm_v,
                           input logic [11:0] iv, input logic [1:0] st,
                           input logic [4:0] sh, input logic [3:0] fin,
                           output logic [31:0] rd_v, output logic [3:0] fo,
                           output int lat);
    @(negedge clk);
    op = o; imm = i_b; s = s_b; rn = rn_v; rm = rm_v; imm_operand = iv;
    stype = st; imm_shift = sh; {cin, zin, nin, vin} = fin;
    out_ready = 1'b1; in_valid = 1'b1;
    #1;
    for (int i = 0; i < 20 && !in_ready; i++) begin
      @(negedge clk); #1;
    end
    @(posedge clk);
    lat = 1;
    // Scramble inputs after acceptance: the result must use the sampled values.
    @(negedge clk);
    in_valid = 1'b0; {cin, zin, nin, vin} = ~fin; rn = ~rn_v; rm = ~rm_v;
    #1;
    while (!out_valid && lat < 20) begin
      @(posedge clk); lat++;
      @(negedge clk); #1;
    end
    checks++;
    if (out_valid !== 1'b1) begin
      errors++;
      $display("FAIL drive_one_timeout: out_valid=%b required 1", out_valid);
    end
    rd_v = rd;
    fo   = {cout, zout, nout, vout};
  endtask

  task automatic test_reset();
    rst = 1'b1; rst8 = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL reset_out_valid: got %b required 0", out_valid);
    end
    checks++;
    if ({rd, cout, zout, nout, vout} !== 36'h0) begin
      errors++; $display("FAIL reset_rd_flags: got %h required 0", {rd, cout, zout, nout, vout});
    end
    rst = 1'b0; rst8 = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++; $display("FAIL reset_in_ready: got %b required 1", in_ready);
    end
  endtask

  task automatic test_lsl();
    logic [31:0] r; logic [3:0] f; int lat;
    drive_one(ORR_OP, 1'b0, 1'b1, 32'h0000_00F0, 32'h0000_000F, 12'h0, LSL, 5'd4, 4'b1110, r, f, lat);
    checks++;
    if ({r, f} !== {32'h0000_00F0, 4'b0000}) begin
      errors++; $display("FAIL orr_lsl4: got %h/%b required 000000f0/0000", r, f);
    end
    checks++;
    if (lat !== 2) begin
      errors++; $display("FAIL latency: got %0d required 2", lat);
    end
    drive_one(MOV_OP, 1'b0, 1'b1, 32'h0, 32'h0000_0003, 12'h0, LSL, 5'd31, 4'b0000, r, f, lat);
    checks++;
    if ({r, f} !== {32'h8000_0000, 4'b1010}) begin
      errors++; $display("FAIL mov_lsl31: got %h/%b required 80000000/1010", r, f);
    end
    drive_one(EOR_OP, 1'b0, 1'b1, 32'h1234_5678, 32'h1234_5678, 12'h0, LSL, 5'd0, 4'b1010, r, f, lat);
    checks++;
    if ({r, f} !== {32'h0, 4'b1100}) begin
      errors++; $display("FAIL eor_s1: got %h/%b required 00000000/1100", r, f);
    end
    drive_one(EOR_OP, 1'b0, 1'b0, 32'h1234_5678, 32'h1234_5678, 12'h0, LSL, 5'd0, 4'b1010, r, f, lat);
    checks++;
    if ({r, f} !== {32'h0, 4'b1010}) begin
      errors++; $display("FAIL eor_s0: got %h/%b required 00000000/1010", r, f);
    end
  endtask

  task automatic test_right_shifts();
    logic [31:0] r; logic [3:0] f; int lat;
    drive_one(BIC_OP, 1'b0, 1'b1, 32'hFFFF_FFFF, 32'h8000_0001, 12'h0, ROR, 5'd0, 4'b1111, r, f, lat);
    checks++;
    if ({r, f} !== {32'h3FFF_FFFF, 4'b1001}) begin
      errors++; $display("FAIL bic_rrx: got %h/%b required 3fffffff/1001", r, f);
    end
    drive_one(MOV_OP, 1'b0, 1'b1, 32'h0, 32'h8000_0000, 12'h0, ASR, 5'd0, 4'b0100, r, f, lat);
    checks++;
    if ({r, f} !== {32'hFFFF_FFFF, 4'b1010}) begin
      errors++; $display("FAIL mov_asr0: got %h/%b required ffffffff/1010", r, f);
    end
    drive_one(MOV_OP, 1'b0, 1'b1, 32'h0, 32'h8000_0000, 12'h0, LSR, 5'd0, 4'b0100, r, f, lat);
    checks++;
    if ({r, f} !== {32'h0, 4'b1100}) begin
      errors++; $display("FAIL mov_lsr0: got %h/%b required 00000000/1100", r, f);
    end
    drive_one(MOV_OP, 1'b0, 1'b1, 32'h0, 32'h0000_0180, 12'h0, LSR, 5'd8, 4'b0000, r, f, lat);
    checks++;
    if ({r, f} !== {32'h0000_0001, 4'b1000}) begin
      errors++; $display("FAIL mov_lsr8: got %h/%b required 00000001/1000", r, f);
    end
    drive_one(AND_OP, 1'b0, 1'b1, 32'hFFFF_FFFF, 32'h8000_0010, 12'h0, ASR, 5'd4, 4'b1000, r, f, lat);
    checks++;
    if ({r, f} !== {32'hF800_0001, 4'b0010}) begin
      errors++; $display("FAIL and_asr4: got %h/%b required f8000001/0010", r, f);
    end
    drive_one(EOR_OP, 1'b0, 1'b1, 32'h0, 32'h1234_56AB, 12'h0, ROR, 5'd8, 4'b0000, r, f, lat);
    checks++;
    if ({r, f} !== {32'hAB12_3456, 4'b1010}) begin
      errors++; $display("FAIL eor_ror8: got %h/%b required ab123456/1010", r, f);
    end
  endtask

  task automatic test_imm_and_ops();
    logic [31:0] r; logic [3:0] f; int lat;
    drive_one(MOV_OP, 1'b1, 1'b1, 32'h0, 32'hFFFF_FFFF, 12'hABC, ROR, 5'd0, 4'b0001, r, f, lat);
    checks++;
    if ({r, f} !== {32'h0000_0ABC, 4'b0001}) begin
      errors++; $display("FAIL mov_imm: got %h/%b required 00000abc/0001", r, f);
    end
    drive_one(MVN_OP, 1'b1, 1'b1, 32'h0, 32'h0, 12'hFFF, LSL, 5'd0, 4'b1000, r, f, lat);
    checks++;
    if ({r, f} !== {32'hFFFF_F000, 4'b1010}) begin
      errors++; $display("FAIL mvn_imm: got %h/%b required fffff000/1010", r, f);
    end
    drive_one(3'b111, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'h0000_0055, 12'h0, LSL, 5'd0, 4'b0111, r, f, lat);
    checks++;
    if ({r, f} !== {32'h0000_0055, 4'b0111}) begin
      errors++; $display("FAIL reserved_op: got %h/%b required 00000055/0111", r, f);
    end
    drive_one(ORR_OP, 1'b1, 1'b1, 32'h0000_0F00, 32'h0, 12'h0F0, LSL, 5'd0, 4'b0000, r, f, lat);
    checks++;
    if ({r, f} !== {32'h0000_0FF0, 4'b0000}) begin
      errors++; $display("FAIL orr_imm: got %h/%b required 00000ff0/0000", r, f);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp_q [4];
    int sent = 0;
    int recv = 0;
    logic fire_in, fire_out;
    exp_q = '{32'h11, 32'h22, 32'h33, 32'h44};
    op = MOV_OP; imm = 1'b1; s = 1'b0; {cin, zin, nin, vin} = 4'b0000;
    for (int cyc = 0; cyc < 40 && recv < 4; cyc++) begin
      @(negedge clk);
      out_ready = (cyc >= 3);
      in_valid  = (sent < 4);
      if (sent < 4) imm_operand = exp_q[sent][11:0];
      #1;
      if (cyc == 2) begin
        checks++;
        if (in_ready !== 1'b0 || sent !== 2) begin
          errors++; $display("FAIL b2b_stall: in_ready=%b accepted=%0d required 0/2", in_ready, sent);
        end
      end
      if (cyc == 2 || cyc == 3) begin
        checks++;
        if (out_valid !== 1'b1 || rd !== exp_q[0]) begin
          errors++; $display("FAIL b2b_hold: out_valid=%b rd=%h required 1/%h", out_valid, rd, exp_q[0]);
        end
      end
      fire_in  = in_valid && in_ready;
      fire_out = out_valid && out_ready;
      if (fire_out) begin
        checks++;
        if (rd !== exp_q[recv]) begin
          errors++; $display("FAIL b2b_order[%0d]: got %h required %h", recv, rd, exp_q[recv]);
        end
        recv++;
      end
      @(posedge clk);
      if (fire_in) sent++;
    end
    in_valid = 1'b0;
    checks++;
    if (recv !== 4) begin
      errors++; $display("FAIL b2b_count: got %0d required 4", recv);
    end
  endtask

  task automatic test_width8_and_reset();
    logic seen = 1'b0;
    int   waited = 0;
    @(negedge clk);
    op8 = AND_OP; imm8 = 1'b1; s8 = 1'b1; rn8 = 8'hF0; rm8 = 8'h00; imm_op8 = 12'h03C;
    stype8 = LSL; sh8 = 3'd0; {cin8, zin8, nin8, vin8} = 4'b0000;
    out_ready8 = 1'b1; in_valid8 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid8 = 1'b0;
    #1;
    while (!out_valid8 && waited < 20) begin
      @(negedge clk); #1; waited++;
    end
    checks++;
    if ({out_valid8, rd8, cout8, zout8, nout8, vout8} !== {1'b1, 8'h30, 4'b0000}) begin
      errors++; $display("FAIL w8_and_imm: got v=%b rd=%h f=%b required 1/30/0000",
                         out_valid8, rd8, {cout8, zout8, nout8, vout8});
    end
    // Fill both stages with out_ready low, then reset.
    @(negedge clk);
    out_ready8 = 1'b0; in_valid8 = 1'b1; rn8 = 8'hFF; imm_op8 = 12'h0AA;
    @(posedge clk);
    @(negedge clk);
    imm_op8 = 12'h055;
    @(posedge clk);
    @(negedge clk);
    in_valid8 = 1'b0;
    #1;
    checks++;
    if ({out_valid8, in_ready8, rd8} !== {1'b1, 1'b0, 8'hAA}) begin
      errors++; $display("FAIL w8_two_in_flight: got v=%b rdy=%b rd=%h required 1/0/aa",
                         out_valid8, in_ready8, rd8);
    end
    rst8 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst8 = 1'b0; out_ready8 = 1'b1;
    #1;
    checks++;
    if ({in_ready8, rd8, cout8, zout8, nout8, vout8} !== {1'b1, 8'h00, 4'b0000}) begin
      errors++; $display("FAIL w8_reset_clear: got rdy=%b rd=%h f=%b required 1/00/0000",
                         in_ready8, rd8, {cout8, zout8, nout8, vout8});
    end
    for (int i = 0; i < 6; i++) begin
      if (out_valid8) seen = 1'b1;
      @(negedge clk); #1;
    end
    checks++;
    if (seen !== 1'b0) begin
      errors++; $display("FAIL w8_reset_discard: out_valid seen=%b required 0", seen);
    end
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; op = '0; imm = 1'b0; s = 1'b0;
    rn = '0; rm = '0; imm_operand = '0; stype = '0; imm_shift = '0;
    {cin, zin, nin, vin} = 4'b0000;
    rst8 = 1'b1; in_valid8 = 1'b0; out_ready8 = 1'b1; op8 = '0; imm8 = 1'b0; s8 = 1'b0;
    rn8 = '0; rm8 = '0; imm_op8 = '0; stype8 = '0; sh8 = '0;
    {cin8, zin8, nin8, vin8} = 4'b0000;

    test_reset();
    test_lsl();
    test_right_shifts();
    test_imm_and_ops();
    test_back_to_back();
    test_width8_and_reset();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/op_logic_pipe.md
OP_LOGIC_PIPE -- requirements
Module: op_logic_pipe

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, meaning datapath width in bits (legal: 8, 16, 32, 64).
REQ-002 The block SHALL have parameter SHW, default $clog2(WIDTH), meaning shift-amount field width.
REQ-003 One clock; reset is synchronous and active-high: port clk, input, 1 bit, rising-edge clock.
REQ-004 Port rst, input, 1 bit, synchronous active-high reset.
REQ-005 Port in_valid, input, 1 bit, request presented.
REQ-006 Port in_ready, output, 1 bit, request accepted when in_valid and in_ready are both high on a clk edge.
REQ-007 Port op, input, 3 bits, operation: 000 AND, 001 ORR, 010 EOR, 011 BIC (Rn & ~op2), 100 MOV (op2), 101 MVN (~op2); 110/111 reserved, treated as MOV.
REQ-008 Ports IMM and S, input, 1 bit each: IMM selects immediate operand 2; S enables flag update.
REQ-009 Ports Rn and Rm, input, WIDTH each: first operand and register operand 2.
REQ-010 Port imm_operand, input, 12 bits, zero-extended (or truncated) to WIDTH when IMM=1.
REQ-011 Ports stype (input, 2 bits: 00 LSL, 01 LSR, 10 ASR, 11 ROR) and imm_shift (input, SHW bits).
REQ-012 Ports carry_in, zero_in, neg_in, ovf_in, input, 1 bit each: current flags.
REQ-013 Port out_valid, output, 1 bit; port out_ready, input, 1 bit; a result transfers when both are high on a clk edge.
REQ-014 Port Rd, output, WIDTH: result.
REQ-015 Ports carry_out, zero_out, neg_out, ovf_out, output, 1 bit each: updated flags.

Function
REQ-016 The block SHALL be a 2-stage pipeline: stage 1 registers the shifted operand 2 and the shifter carry; stage 2 registers the logic result and flags.
REQ-017 Latency SHALL be 2 cycles from acceptance to out_valid with no back-pressure; throughput 1 per cycle.
REQ-018 Each stage SHALL advance when it is empty or when its contents advance the same cycle; in_ready = !s1_valid | (!s2_valid | out_ready).
REQ-019 Rd and flag outputs SHALL hold stable while out_valid=1 and out_ready=0; no transaction is dropped or duplicated.
REQ-020 IMM=1: op2 = imm_operand; shifter carry = carry_in; stype and imm_shift ignored.
REQ-021 IMM=0, n=imm_shift!=0: LSL op2=Rm<<n, c=Rm[WIDTH-n]; LSR op2=Rm>>n, c=Rm[n-1]; ASR arithmetic shift, c=Rm[n-1]; ROR rotate right n, c=Rm[n-1].
REQ-022 IMM=0, n=0: LSL op2=Rm, c=carry_in; LSR op2=0, c=Rm[WIDTH-1]; ASR op2=all copies of Rm[WIDTH-1], c=Rm[WIDTH-1]; ROR means RRX: op2={carry_in, Rm[WIDTH-1:1]}, c=Rm[0].
REQ-023 carry_in, zero_in, neg_in, ovf_in SHALL be sampled at acceptance and carried with the transaction.
REQ-024 S=1: neg_out=Rd[WIDTH-1], zero_out=(Rd==0), carry_out=shifter carry, ovf_out=sampled ovf_in.
REQ-025 S=0: all flag outputs SHALL equal the sampled input flags.
REQ-026 Outputs SHALL be combinationally derived only from stage-2 registers.

Reset
REQ-027 While rst=1 at a clk edge, both stage valids, Rd and all flag outputs SHALL clear to 0; in_ready SHALL be 1 after reset.
REQ-028 Reset mid-operation SHALL discard all in-flight transactions; no out_valid SHALL appear for them.

Verification
REQ-029 WIDTH=32, ORR, IMM=0, Rn=0x0000_00F0, Rm=0x0000_000F, LSL 4, S=1 -> Rd=0x0000_00F0, Z=0, N=0, C=0, out_valid 2 cycles after acceptance.
REQ-030 BIC, Rn=0xFFFF_FFFF, Rm=0x8000_0001, ROR 0 (RRX), carry_in=1, S=1 -> op2=0xC000_0000, Rd=0x3FFF_FFFF, C=1.
REQ-031 EOR, Rn=Rm=0x1234_5678, LSL 0, S=1, carry_in=1 -> Rd=0, Z=1, C=1; same with S=0, zero_in=0 -> Z=0.
REQ-032 MOV, Rm=0x8000_0000, ASR 0, S=1 -> Rd=0xFFFF_FFFF, N=1, C=1; LSR 0 -> Rd=0, Z=1, C=1.
REQ-033 Back-to-back stream of 4 requests with out_ready low for 3 cycles -> in_ready drops after 2 accepted, outputs held, all 4 results delivered in order.
REQ-034 WIDTH=8, AND, Rn=0xF0, IMM=1, imm_operand=0x03C -> Rd=0x30; rst asserted with 2 in flight -> no out_valid follows.
